chord_player: RTL and testbench

Three-voice chord synthesiser sitting directly downstream of the song reader. It latches the three note slots and per-slot beat durations presented with `new_note` and counts each slot down on `beat`. It generates a mixed square-wave PCM sample per `generate_next_sample` request and pulses `note_done` when every slot has expired. Its sample output feeds the codec/audio interface.

---
 rtl/chord_player_pkg.sv | 30 +++
 rtl/chord_player_note_step_lut.sv | 13 +
 rtl/chord_player.sv | 94 +++++++++
 tb/tb_chord_player.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/chord_player_pkg.sv
// Shared widths, mixer amplitude and the note-to-phase-step table for the
// three-voice chord player.
package chord_player_pkg;

    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int PHASE_W  = 22;
    localparam int SAMPLE_W = 16;
    localparam int VOICES   = 3;

    // One third of full scale, so three voices in phase sum to +/-32766.
    localparam logic signed [SAMPLE_W-1:0] AMP = 16'sd10922;

    // round(440 * 2^((n-49)/12) * 2^22 / 48000); entry 0 is the rest note.
    localparam logic [PHASE_W-1:0] STEP_TABLE [64] = '{
        22'd0,
        22'd2403,  22'd2546,  22'd2697,  22'd2858,  22'd3028,  22'd3208,
        22'd3398,  22'd3600,  22'd3815,  22'd4041,  22'd4282,  22'd4536,
        22'd4806,  22'd5092,  22'd5395,  22'd5715,  22'd6055,  22'd6415,
        22'd6797,  22'd7201,  22'd7629,  22'd8083,  22'd8563,  22'd9072,
        22'd9612,  22'd10184, 22'd10789, 22'd11431, 22'd12110, 22'd12830,
        22'd13593, 22'd14402, 22'd15258, 22'd16165, 22'd17127, 22'd18145,
        22'd19224, 22'd20367, 22'd21578, 22'd22861, 22'd24221, 22'd25661,
        22'd27187, 22'd28803, 22'd30516, 22'd32331, 22'd34253, 22'd36290,
        22'd38448, 22'd40734, 22'd43156, 22'd45722, 22'd48441, 22'd51322,
        22'd54373, 22'd57607, 22'd61032, 22'd64661, 22'd68506, 22'd72580,
        22'd76896, 22'd81468, 22'd86312
    };

endpackage

// File: rtl/chord_player_note_step_lut.sv
// Combinational note index to phase-accumulator step lookup, one per voice.
module note_step_lut
    import chord_player_pkg::*;
(
    input  logic [NOTE_W-1:0]  note,
    output logic [PHASE_W-1:0] step
);

    always_comb begin
        step = STEP_TABLE[note];
    end

endmodule

// File: rtl/chord_player.sv
// Three-voice square-wave chord player: latches note slots on new_note,
// counts durations down on beat and mixes one PCM sample per request.
module chord_player
    import chord_player_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       play,
    input  logic                       beat,
    input  logic                       new_note,
    input  logic [3*NOTE_W-1:0]        notes_in,
    input  logic [3*DUR_W-1:0]         durations_in,
    input  logic                       generate_next_sample,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       new_sample_ready,
    output logic                       note_done,
    output logic [2:0]                 voice_active
);

    // Voice index i is bit position i of the packed buses, so slot0 (the MSB
    // field of notes_in) is voice 2 and drives voice_active[2].
    logic [NOTE_W-1:0]          note_q      [VOICES];
    logic [DUR_W-1:0]           remaining_q [VOICES];
    logic [DUR_W-1:0]           remaining_d [VOICES];
    logic [PHASE_W-1:0]         phase_q     [VOICES];
    logic [PHASE_W-1:0]         phase_d     [VOICES];
    logic [PHASE_W-1:0]         phase_adv   [VOICES];
    logic [PHASE_W-1:0]         step        [VOICES];
    logic signed [SAMPLE_W-1:0] mix_d;
    logic                       any_left;
    logic                       any_next;
    logic                       note_done_d;

    note_step_lut u_lut0 (.note(note_q[0]), .step(step[0]));
    note_step_lut u_lut1 (.note(note_q[1]), .step(step[1]));
    note_step_lut u_lut2 (.note(note_q[2]), .step(step[2]));

    always_comb begin
        voice_active = '0;
        any_left     = 1'b0;
        any_next     = 1'b0;
        mix_d        = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            voice_active[i] = (note_q[i] != '0) && (remaining_q[i] != '0);
            remaining_d[i]  = remaining_q[i];
            phase_adv[i]    = voice_active[i] ? phase_q[i] + step[i] : '0;
            phase_d[i]      = phase_q[i];

            if (new_note) begin
                remaining_d[i] = durations_in[i*DUR_W +: DUR_W];
                phase_d[i]     = '0;
            end else begin
                if (beat && play && (remaining_q[i] != '0))
                    remaining_d[i] = remaining_q[i] - DUR_W'(1);
                if (generate_next_sample && play)
                    phase_d[i] = phase_adv[i];
            end

            if (voice_active[i])
                mix_d = mix_d + (phase_adv[i][PHASE_W-1] ? -AMP : AMP);

            any_left = any_left | (remaining_q[i] != '0);
            any_next = any_next | (remaining_d[i] != '0);
        end
        // A load counts as a fresh start: all-zero durations finish at once,
        // and any nonzero load masks a decrement that would have finished.
        note_done_d = new_note ? (durations_in == '0) : (any_left && !any_next);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                note_q[i]      <= '0;
                remaining_q[i] <= '0;
                phase_q[i]     <= '0;
            end
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            note_done        <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (new_note)
                    note_q[i] <= notes_in[i*NOTE_W +: NOTE_W];
                remaining_q[i] <= remaining_d[i];
                phase_q[i]     <= phase_d[i];
            end
            new_sample_ready <= generate_next_sample;
            if (generate_next_sample)
                sample_out <= play ? mix_d : '0;
            note_done <= note_done_d;
        end
    end

endmodule

// File: tb/tb_chord_player.sv
// Directed self-checking bench for chord_player with hand-computed samples.
module tb_chord_player;
    import chord_player_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic                       play;
    logic                       beat;
    logic                       new_note;
    logic [3*NOTE_W-1:0]        notes_in;
    logic [3*DUR_W-1:0]         durations_in;
    logic                       generate_next_sample;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       new_sample_ready;
    logic                       note_done;
    logic [2:0]                 voice_active;

    int errors = 0;
    int checks = 0;

    chord_player dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .play                 (play),
        .beat                 (beat),
        .new_note             (new_note),
        .notes_in             (notes_in),
        .durations_in         (durations_in),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .note_done            (note_done),
        .voice_active         (voice_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] n0, input logic [5:0] n1, input logic [5:0] n2,
                        input logic [5:0] d0, input logic [5:0] d1, input logic [5:0] d2);
        notes_in     = {n0, n1, n2};
        durations_in = {d0, d1, d2};
        new_note     = 1'b1;
        tick();
        new_note     = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; play = 1'b0; beat = 1'b0; new_note = 1'b0;
        notes_in = '0; durations_in = '0; generate_next_sample = 1'b0;
        tick();
        tick();
        check("rst_sample", int'(sample_out), 0);
        check("rst_ready", int'(new_sample_ready), 0);
        check("rst_done", int'(note_done), 0);
        check("rst_active", int'(voice_active), 0);
        reset_n = 1'b1;
        play    = 1'b1;
        tick();

        // Note 49 with a timed rest beside it, four beats
        load(6'd49, 6'd0, 6'd0, 6'd4, 6'd4, 6'd0);
        check("t1_active_load", int'(voice_active), 3'b100);
        check("t1_done_load", int'(note_done), 0);
        for (int b = 1; b <= 4; b++) begin
            beat = 1'b1;
            tick();
            beat = 1'b0;
            check($sformatf("t1_active_b%0d", b), int'(voice_active), (b < 4) ? 3'b100 : 3'b000);
            check($sformatf("t1_done_b%0d", b), int'(note_done), (b == 4) ? 1 : 0);
        end
        tick();
        check("t1_done_after", int'(note_done), 0);

        // Full chord, one request: three voices in phase at +AMP
        load(6'd49, 6'd49, 6'd49, 6'd8, 6'd8, 6'd8);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        check("t2_ready", int'(new_sample_ready), 1);
        check("t2_sample", int'(sample_out), 32766);
        check("t2_phase", int'(dut.phase_q[2]), 38448);
        tick();
        check("t2_ready_low", int'(new_sample_ready), 0);
        check("t2_sample_held", int'(sample_out), 32766);

        // Single voice, 55 back-to-back requests; bit 21 sets on the 55th
        load(6'd49, 6'd0, 6'd0, 6'd63, 6'd0, 6'd0);
        generate_next_sample = 1'b1;
        for (int r = 1; r <= 55; r++) begin
            tick();
            check($sformatf("t3_ready_r%0d", r), int'(new_sample_ready), 1);
            check($sformatf("t3_sample_r%0d", r), int'(sample_out), (r < 55) ? 10922 : -10922);
        end
        generate_next_sample = 1'b0;
        check("t3_phase", int'(dut.phase_q[2]), 2114640);

        // Paused: beats ignored, samples forced to zero, phases frozen
        play = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            beat = 1'b1;
            tick();
            beat = 1'b0;
        end
        check("t4_remaining", int'(dut.remaining_q[2]), 63);
        check("t4_active", int'(voice_active), 3'b100);
        for (int r = 1; r <= 3; r++) begin
            generate_next_sample = 1'b1;
            tick();
            generate_next_sample = 1'b0;
            check($sformatf("t4_ready_r%0d", r), int'(new_sample_ready), 1);
            check($sformatf("t4_sample_r%0d", r), int'(sample_out), 0);
        end
        check("t4_phase", int'(dut.phase_q[2]), 2114640);
        play = 1'b1;

        // Load on the final beat of the previous chord
        load(6'd30, 6'd0, 6'd0, 6'd2, 6'd0, 6'd0);
        beat = 1'b1;
        tick();
        check("t5_remaining_mid", int'(dut.remaining_q[2]), 1);
        notes_in     = {6'd40, 6'd40, 6'd0};
        durations_in = {6'd5, 6'd3, 6'd0};
        new_note     = 1'b1;
        tick();
        new_note = 1'b0;
        beat     = 1'b0;
        check("t5_done", int'(note_done), 0);
        check("t5_active", int'(voice_active), 3'b110);
        check("t5_rem2", int'(dut.remaining_q[2]), 5);
        check("t5_rem1", int'(dut.remaining_q[1]), 3);
        tick();
        check("t5_done_after", int'(note_done), 0);

        // Beat and request together: sample sees the pre-decrement voices
        for (int b = 0; b < 2; b++) begin
            beat = 1'b1;
            tick();
            beat = 1'b0;
        end
        check("t6_rem1", int'(dut.remaining_q[1]), 1);
        beat = 1'b1;
        generate_next_sample = 1'b1;
        tick();
        beat = 1'b0;
        generate_next_sample = 1'b0;
        check("t6_sample", int'(sample_out), 21844);
        check("t6_active", int'(voice_active), 3'b100);

        // All-zero durations finish immediately
        load(6'd10, 6'd20, 6'd30, 6'd0, 6'd0, 6'd0);
        check("t7_done", int'(note_done), 1);
        check("t7_active", int'(voice_active), 0);
        tick();
        check("t7_done_after", int'(note_done), 0);

        // Asynchronous reset mid-chord
        load(6'd49, 6'd49, 6'd0, 6'd8, 6'd8, 6'd0);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        check("t8_pre_sample", int'(sample_out), 21844);
        #2;
        reset_n = 1'b0;
        #1;
        check("t8_rst_sample", int'(sample_out), 0);
        check("t8_rst_ready", int'(new_sample_ready), 0);
        check("t8_rst_active", int'(voice_active), 0);
        check("t8_rst_done", int'(note_done), 0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t8_idle_done_c%0d", c), int'(note_done), 0);
            check($sformatf("t8_idle_active_c%0d", c), int'(voice_active), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
